// File: rtl/spi_pkg.sv
// spi_pkg -- state encodings and SPI mode constant shared by axis_spi_master.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_NEXT     = 3'd4,
        ST_HOLD     = 3'd5
    } spi_state_t;

    // {CPOL, CPHA}: mode 0, sck idles low and data is captured on the rising edge
    localparam logic [1:0] SPI_MODE = 2'b00;

    function automatic logic is_accept_state(input spi_state_t s);
        return (s == ST_IDLE) || (s == ST_NEXT);
    endfunction

endpackage

// File: rtl/spi_prescaler.sv
// spi_prescaler -- half-period tick generator; the period is captured on i_load
// so a prescale change only affects words accepted afterwards.
module spi_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick
);

    logic [PRESCALE_WIDTH-1:0] r_period;
    logic [PRESCALE_WIDTH-1:0] r_count;

    // Down-counter that reloads itself, giving a tick every prescale+1 cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_period <= {PRESCALE_WIDTH{1'b0}};
            r_count  <= {PRESCALE_WIDTH{1'b0}};
        end else if (i_load) begin
            r_period <= i_prescale;
            r_count  <= i_prescale;
        end else if (r_count == {PRESCALE_WIDTH{1'b0}}) begin
            r_count  <= r_period;
        end else begin
            r_count  <= r_count - PRESCALE_WIDTH'(1);
        end
    end

    assign o_tick = (r_count == {PRESCALE_WIDTH{1'b0}});

endmodule

// File: rtl/axis_spi_master.sv
// axis_spi_master -- AXI-Stream to SPI mode-0 master, MSB first.
// Receive path is built only when AXIS_SPI_MASTER_RX_EN is defined.
module axis_spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     input_axis_tdata,
    input  logic                      input_axis_tvalid,
    output logic                      input_axis_tready,
    input  logic                      input_axis_tlast,
    output logic [DATA_WIDTH-1:0]     output_axis_tdata,
    output logic                      output_axis_tvalid,
    input  logic                      output_axis_tready,
    output logic                      output_axis_tlast,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      cs,
    output logic                      sck,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic             SCK_IDLE = SPI_MODE[1];

    spi_state_t            r_state;
    logic [DATA_WIDTH-2:0] r_tx_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_tlast;
    logic                  r_hold_cs_hi;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_rx_room;
    logic                  w_word_done;

    assign w_accept          = input_axis_tvalid && input_axis_tready;
    assign input_axis_tready = !rst && is_accept_state(r_state) && w_rx_room;
    assign w_word_done       = (r_state == ST_SHIFT_HI) && w_tick && (r_bit_cnt == LAST_BIT);

    spi_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_prescale (prescale),
        .o_tick     (w_tick)
    );

    // Transfer sequencer; cs/sck/mosi/busy are registered straight out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            cs           <= 1'b1;
            sck          <= SCK_IDLE;
            mosi         <= 1'b0;
            busy         <= 1'b0;
            r_tx_shift   <= {(DATA_WIDTH-1){1'b0}};
            r_bit_cnt    <= {CNT_W{1'b0}};
            r_tlast      <= 1'b0;
            r_hold_cs_hi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_SETUP;
                        cs         <= 1'b0;
                        busy       <= 1'b1;
                        mosi       <= input_axis_tdata[DATA_WIDTH-1];
                        r_tx_shift <= input_axis_tdata[DATA_WIDTH-2:0];
                        r_tlast    <= input_axis_tlast;
                        r_bit_cnt  <= {CNT_W{1'b0}};
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT_HI;
                        sck     <= ~SCK_IDLE;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tick) begin
                        sck <= SCK_IDLE;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state      <= r_tlast ? ST_HOLD : ST_NEXT;
                            r_hold_cs_hi <= 1'b0;
                        end else begin
                            r_state    <= ST_SHIFT_LO;
                            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                            mosi       <= r_tx_shift[DATA_WIDTH-2];
                            r_tx_shift <= r_tx_shift << 1;
                        end
                    end
                end
                ST_NEXT: begin
                    // Back-to-back word: cs stays low and no setup phase is inserted
                    if (w_accept) begin
                        r_state    <= ST_SHIFT_LO;
                        mosi       <= input_axis_tdata[DATA_WIDTH-1];
                        r_tx_shift <= input_axis_tdata[DATA_WIDTH-2:0];
                        r_tlast    <= input_axis_tlast;
                        r_bit_cnt  <= {CNT_W{1'b0}};
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (!r_hold_cs_hi) begin
                            cs           <= 1'b1;
                            r_hold_cs_hi <= 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            busy         <= 1'b0;
                            r_hold_cs_hi <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    cs      <= 1'b1;
                    sck     <= SCK_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_SPI_MASTER_RX_EN
    logic [DATA_WIDTH-1:0] r_rx_shift;

    // Only accept a new word when the finished rx word cannot be overwritten
    assign w_rx_room = !output_axis_tvalid || output_axis_tready;

    // miso is captured on the edge that raises sck
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift         <= {DATA_WIDTH{1'b0}};
            output_axis_tdata  <= {DATA_WIDTH{1'b0}};
            output_axis_tvalid <= 1'b0;
            output_axis_tlast  <= 1'b0;
        end else begin
            if ((r_state == ST_SHIFT_LO) && w_tick) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], miso};
            end
            if (w_word_done) begin
                output_axis_tdata  <= r_rx_shift;
                output_axis_tvalid <= 1'b1;
                output_axis_tlast  <= r_tlast;
            end else if (output_axis_tvalid && output_axis_tready) begin
                output_axis_tvalid <= 1'b0;
            end
        end
    end
`else
    logic w_unused_rx;

    assign w_rx_room          = 1'b1;
    assign output_axis_tdata  = {DATA_WIDTH{1'b0}};
    assign output_axis_tvalid = 1'b0;
    assign output_axis_tlast  = 1'b0;
    assign w_unused_rx        = &{1'b0, miso, output_axis_tready, w_word_done};
`endif

endmodule

// File: tb/tb_axis_spi_master.sv
// tb_axis_spi_master -- directed self-checking bench for axis_spi_master (mode 0, DATA_WIDTH=8).
// Receive-side checks are compiled in when AXIS_SPI_MASTER_RX_EN is defined.
module tb_axis_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  input_axis_tdata = 8'h00;
    logic        input_axis_tvalid = 1'b0;
    logic        input_axis_tready;
    logic        input_axis_tlast = 1'b0;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready = 1'b0;
    logic        output_axis_tlast;
    logic [15:0] prescale = 16'd0;
    logic        cs, sck, mosi, miso, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus monitor state
    logic        sck_q = 1'b0;
    logic        cs_q  = 1'b1;
    logic [31:0] mosi_bits = 32'h0;
    int          rise_cnt = 0, hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
    int          cs_lo_run = 0, last_cs_lo = 0, cs_rise_cnt = 0;
    logic        tvalid_seen = 1'b0;
    logic [8:0]  rxq[$];

    assign miso = mosi;

    always #5 clk = ~clk;

    axis_spi_master #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .input_axis_tlast   (input_axis_tlast),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .prescale           (prescale),
        .cs                 (cs),
        .sck                (sck),
        .mosi               (mosi),
        .miso               (miso),
        .busy               (busy)
    );

    // Handshake capture at the edge, then bus phase measurement just after it
    always @(posedge clk) begin
        if (output_axis_tvalid && output_axis_tready) rxq.push_back({output_axis_tlast, output_axis_tdata});
        if (output_axis_tvalid) tvalid_seen = 1'b1;
        #2;
        if (sck && !sck_q) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[30:0], mosi};
            last_lo = lo_run;
            lo_run = 0;
        end
        if (!sck && sck_q) begin
            last_hi = hi_run;
            hi_run = 0;
        end
        if (sck) hi_run++;
        else if (!cs) lo_run++;
        else lo_run = 0;
        if (cs && !cs_q) begin
            last_cs_lo = cs_lo_run;
            cs_lo_run = 0;
            cs_rise_cnt++;
        end
        if (!cs) cs_lo_run++;
        sck_q = sck;
        cs_q = cs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input string tag, input logic [7:0] d, input logic l, input int budget);
        int n = 0;
        @(negedge clk);
        input_axis_tdata = d;
        input_axis_tlast = l;
        input_axis_tvalid = 1'b1;
        while (!input_axis_tready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, {31'd0, n < budget}, 32'd1);
        @(negedge clk);
        input_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, n < budget}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int r0, c0, n, nr;

        // Reset state
        @(negedge clk);
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_tready", {31'd0, input_axis_tready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx", {22'd0, output_axis_tvalid, output_axis_tlast, output_axis_tdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tready", {31'd0, input_axis_tready}, 32'd1);

        // prescale 0, single word 0xA5 with tlast
        output_axis_tready = 1'b1;
        prescale = 16'd0;
        r0 = rise_cnt;
        send_word("a5", 8'hA5, 1'b1, 10);
        check("a5_busy", {31'd0, busy}, 32'd1);
        check("a5_cs_low", {31'd0, cs}, 32'd0);
        check("a5_tready_busy", {31'd0, input_axis_tready}, 32'd0);
        n = 0;
        while (!cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a5_cs_rise", {31'd0, n < 100}, 32'd1);
        check("a5_busy_cs_hi", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("a5_busy_end", {31'd0, busy}, 32'd0);
        check("a5_mosi", mosi_bits[7:0], 32'hA5);
        check("a5_rises", rise_cnt - r0, 32'd8);
        check("a5_hi", last_hi, 32'd1);
        check("a5_lo", last_lo, 32'd1);
        check("a5_cs_len", last_cs_lo, 32'd18);
`ifdef AXIS_SPI_MASTER_RX_EN
        check("a5_rx_n", rxq.size(), 32'd1);
        if (rxq.size() > 0) check("a5_rx", {23'd0, rxq.pop_front()}, 32'h1A5);
`endif

        // prescale 3, two words, cs held across the word boundary
        prescale = 16'd3;
        r0 = rise_cnt;
        c0 = cs_rise_cnt;
        send_word("w12", 8'h12, 1'b0, 10);
        send_word("w34", 8'h34, 1'b1, 200);
        wait_idle("w34", 200);
        check("b_mosi", mosi_bits[15:0], 32'h1234);
        check("b_rises", rise_cnt - r0, 32'd16);
        check("b_hi", last_hi, 32'd4);
        check("b_lo", last_lo, 32'd4);
        check("b_cs_rises", cs_rise_cnt - c0, 32'd1);
        check("b_cs_len", last_cs_lo, 32'd137);
`ifdef AXIS_SPI_MASTER_RX_EN
        check("b_rx_n", rxq.size(), 32'd2);
        if (rxq.size() == 2) begin
            check("b_rx0", {23'd0, rxq.pop_front()}, 32'h012);
            check("b_rx1", {23'd0, rxq.pop_front()}, 32'h134);
        end
`endif

        // rx consumer stalled, three words
        prescale = 16'd0;
        output_axis_tready = 1'b0;
        r0 = rise_cnt;
        c0 = cs_rise_cnt;
`ifdef AXIS_SPI_MASTER_RX_EN
        send_word("c1", 8'h01, 1'b0, 10);
        n = 0;
        while (!output_axis_tvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c1_rx_valid", {31'd0, n < 100}, 32'd1);
        input_axis_tdata = 8'h02;
        input_axis_tlast = 1'b0;
        input_axis_tvalid = 1'b1;
        nr = 0;
        repeat (8) begin
            @(negedge clk);
            if (input_axis_tready) nr++;
        end
        check("c2_withheld", nr, 32'd0);
        check("c1_rx_hold", {23'd0, output_axis_tlast, output_axis_tdata}, 32'h001);
        output_axis_tready = 1'b1;
        @(negedge clk);
        input_axis_tvalid = 1'b0;
        send_word("c3", 8'h03, 1'b1, 100);
        wait_idle("c3", 100);
        check("c_rx_n", rxq.size(), 32'd3);
        if (rxq.size() == 3) begin
            check("c_rx0", {23'd0, rxq.pop_front()}, 32'h001);
            check("c_rx1", {23'd0, rxq.pop_front()}, 32'h002);
            check("c_rx2", {23'd0, rxq.pop_front()}, 32'h103);
        end
`else
        send_word("c1", 8'h01, 1'b0, 10);
        send_word("c2", 8'h02, 1'b0, 40);
        send_word("c3", 8'h03, 1'b1, 40);
        wait_idle("c3", 100);
        check("c_cs_len", last_cs_lo, 32'd52);
        check("c_tvalid_never", {31'd0, tvalid_seen}, 32'd0);
`endif
        check("c_mosi", mosi_bits[23:0], 32'h010203);
        check("c_cs_rises", cs_rise_cnt - c0, 32'd1);

        // reset during bit 4 of 0xFF
        output_axis_tready = 1'b1;
        prescale = 16'd1;
        r0 = rise_cnt;
        send_word("ff", 8'hFF, 1'b1, 10);
        n = 0;
        while ((rise_cnt - r0) < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ff_bit4", {31'd0, n < 100}, 32'd1);
        check("ff_cs_low", {31'd0, cs}, 32'd0);
        rst = 1'b1;
        #1;
        check("ff_rst_cs", {31'd0, cs}, 32'd1);
        check("ff_rst_sck", {31'd0, sck}, 32'd0);
        check("ff_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("ff_no_rx", {31'd0, output_axis_tvalid}, 32'd0);
        check("ff_no_rxq", rxq.size(), 32'd0);
        prescale = 16'd0;
        r0 = rise_cnt;
        send_word("0f", 8'h0F, 1'b1, 10);
        wait_idle("0f", 100);
        check("0f_mosi", mosi_bits[7:0], 32'h0F);
        check("0f_rises", rise_cnt - r0, 32'd8);
        check("0f_cs_len", last_cs_lo, 32'd18);
`ifdef AXIS_SPI_MASTER_RX_EN
        check("0f_rx_n", rxq.size(), 32'd1);
        if (rxq.size() > 0) check("0f_rx", {23'd0, rxq.pop_front()}, 32'h10F);
`endif

        // prescale changed 1 -> 7 while a word is in flight
        prescale = 16'd1;
        send_word("5a", 8'h5A, 1'b1, 10);
        prescale = 16'd7;
        wait_idle("5a", 200);
        check("5a_hi", last_hi, 32'd2);
        check("5a_lo", last_lo, 32'd2);
        check("5a_cs_len", last_cs_lo, 32'd36);
        check("5a_mosi", mosi_bits[7:0], 32'h5A);
        send_word("c3w", 8'hC3, 1'b1, 10);
        wait_idle("c3w", 400);
        check("c3_hi", last_hi, 32'd8);
        check("c3_lo", last_lo, 32'd8);
        check("c3_cs_len", last_cs_lo, 32'd144);
        check("c3_mosi", mosi_bits[7:0], 32'hC3);
`ifdef AXIS_SPI_MASTER_RX_EN
        check("e_rx_n", rxq.size(), 32'd2);
`else
        check("end_tvalid_never", {31'd0, tvalid_seen}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_spi_master.md
AXIS_SPI_MASTER -- requirements
Module: axis_spi_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI word.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16, width of prescale input.
REQ-003 SHALL have ports, clock and reset first (name  direction  width  meaning):
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  input_axis_tdata  in  DATA_WIDTH  word to transmit
  input_axis_tvalid  in  1  tx word valid
  input_axis_tready  out  1  tx word accepted
  input_axis_tlast  in  1  last word of transaction; deassert cs after it
  output_axis_tdata  out  DATA_WIDTH  received word
  output_axis_tvalid  out  1  rx word valid
  output_axis_tready  in  1  rx word consumed
  output_axis_tlast  out  1  copy of tlast of the tx word that produced it
  prescale  in  PRESCALE_WIDTH  sck half-period = prescale+1 clk cycles
  cs  out  1  chip select, active-low
  sck  out  1  SPI clock, idle low
  mosi  out  1  serial data out
  miso  in  1  serial data in
  busy  out  1  high whenever state is not IDLE

Function
REQ-004 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-005 SHALL use states IDLE, SETUP, SHIFT_LO, SHIFT_HI, NEXT, HOLD.
REQ-006 input_axis_tready SHALL be high only in IDLE or NEXT and only when the rx holding register is empty or output_axis_tready is high in that cycle.
REQ-007 On tvalid&tready: latch tdata, tlast, prescale; IDLE->SETUP with cs low; NEXT->SHIFT_LO directly.
REQ-008 SETUP SHALL last one half-period with sck=0, mosi=word MSB, then go to SHIFT_LO.
REQ-009 SHIFT_LO: sck=0, mosi=current bit, one half-period; SHIFT_HI: sck=1, one half-period, miso sampled on the clk cycle sck rises.
REQ-010 After DATA_WIDTH SHIFT_HI phases: load rx word into output register (tvalid=1) and go to HOLD if latched tlast, else NEXT.
REQ-011 NEXT SHALL hold cs low, sck low, until the next tx word is accepted.
REQ-012 HOLD SHALL keep cs low one half-period, then cs high for one half-period, then IDLE.
REQ-013 prescale changes SHALL affect only words accepted afterwards.
REQ-014 output_axis_tvalid SHALL stay set until output_axis_tready; no rx word SHALL ever be dropped or overwritten.
REQ-015 With prescale=0 a DATA_WIDTH=8 word SHALL occupy exactly 16 clk cycles from first SHIFT_LO to NEXT/HOLD entry.

Reset
REQ-016 On rst: cs=1, sck=0, mosi=0, input_axis_tready=0, output_axis_tvalid=0, output_axis_tdata=0, output_axis_tlast=0, busy=0, state IDLE.
REQ-017 rst mid-transfer SHALL raise cs immediately; the partial word SHALL be discarded.

Configuration
REQ-018 Macro AXIS_SPI_MASTER_RX_EN defined: receive path as above.
REQ-019 Macro undefined: miso ignored, output_axis_tvalid/tdata/tlast tied 0, rx-register condition removed from REQ-006.

Structure
REQ-020 State encodings and the SPI mode constant SHALL live in shared package spi_pkg.
REQ-021 Half-period tick generation SHALL be sub-module spi_prescaler (load, count, tick out).

Verification
REQ-022 prescale=0, one word 0xA5 tlast=1, miso tied to mosi -> mosi 1,0,1,0,0,1,0,1 on sck rising edges; rx 0xA5 tlast=1; cs high after HOLD.
REQ-023 prescale=3, words 0x12,0x34 (tlast on second) -> each sck phase 4 clk cycles; cs stays low between words; two rx words, tlast on 0x34 only.
REQ-024 output_axis_tready=0, send 3 words -> second word's tready withheld until first rx consumed; no word lost; order 1,2,3.
REQ-025 rst asserted during bit 4 of 0xFF -> cs=1, sck=0 same cycle; no rx word emitted; next word 0x0F transfers correctly.
REQ-026 prescale changed 1->7 mid-word -> current word keeps 2-cycle phases; next word uses 8-cycle phases.
REQ-027 Build without AXIS_SPI_MASTER_RX_EN, output_axis_tready=0 -> back-to-back words still accepted; output_axis_tvalid stays 0.
